// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: size encodings, FSM states,
// exception cause bit positions and lane helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int unsigned CAUSE_RUNAL = 0;
  localparam int unsigned CAUSE_WUNAL = 1;
  localparam int unsigned CAUSE_OOR   = 2;

  // Illegal size counts as unaligned so it shares the same exception path.
  function automatic logic is_unaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      SZ_WORD: return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] a);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (sz)
      SZ_BYTE: return {24'h0, sh[7:0]};
      SZ_HALF: return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store unit <-> data-memory controller bus: read handshake, write strobe
// and exception reporting.
interface dmem_if #(parameter int unsigned ADDR_W = 32);
  logic              rd_req;
  logic              rd_ready;
  logic [ADDR_W-1:0] RADDR;
  logic [1:0]        RWHBS;
  logic              rd_valid;
  logic [31:0]       RAMData;
  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [1:0]        WWHBS;
  logic [31:0]       DIN;
  logic              RUnalExc;
  logic              WUnalExc;
  logic              oor_err;
  logic [2:0]        exc_cause;
  logic              exc_clr;

  modport master (
    output rd_req, RADDR, RWHBS, WE, WADDR, WWHBS, DIN, exc_clr,
    input  rd_ready, rd_valid, RAMData, RUnalExc, WUnalExc, oor_err, exc_cause
  );

  modport slave (
    input  rd_req, RADDR, RWHBS, WE, WADDR, WWHBS, DIN, exc_clr,
    output rd_ready, rd_valid, RAMData, RUnalExc, WUnalExc, oor_err, exc_cause
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 data array: registered read port, byte-enabled write port.
// A same-edge read and write to one word returns the old contents.
module dmem_array #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int unsigned b = 0; b < 4; b++) begin
      if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: wait-stated read handshake, byte/half/word lanes,
// range/alignment exceptions. DMEM_MMIO_TIMER_EN adds a cycle timer at MMIO_BASE.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic CLK,
  input  logic rst,
  dmem_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = ADDR_W - 2;
  localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);

  state_e      state;
  logic [3:0]  cnt;
  logic        rd_ready_q, rd_valid_q, runal_q, wunal_q, oor_q;
  logic [2:0]  cause_q;
  logic [1:0]  lat_sz, lat_a;
  logic        lat_ok, lat_mmio;
  logic [31:0] lat_tmr;
  logic [31:0] arr_rdata, wdata;
  logic [3:0]  wbe;
  logic [IW-1:0] ridx, widx;
  logic        accept, r_mmio, w_mmio, r_unal, r_oor, w_unal, w_oor;
  logic        runal_set, wunal_set, oor_set;
  logic [2:0]  cause_set;
  logic [31:0] tmr;

  assign ridx   = bus.RADDR[ADDR_W-1:2];
  assign widx   = bus.WADDR[ADDR_W-1:2];
  assign accept = (state == IDLE) && bus.rd_req;

`ifdef DMEM_MMIO_TIMER_EN
  localparam logic [ADDR_W-1:0] MMIO_A = MMIO_BASE[ADDR_W-1:0];

  assign r_mmio = bus.RADDR == MMIO_A;
  assign w_mmio = bus.WADDR == MMIO_A;

  always_ff @(posedge CLK) begin
    if (rst) tmr <= '0;
    else if (bus.WE && w_mmio && bus.WWHBS == SZ_WORD) tmr <= bus.DIN;
    else tmr <= tmr + 32'd1;
  end
`else
  assign r_mmio = 1'b0;
  assign w_mmio = 1'b0;
  assign tmr    = '0;
`endif

  // The MMIO word is decoded ahead of the range check and only accepts word size.
  assign r_unal = r_mmio ? (bus.RWHBS != SZ_WORD) : is_unaligned(bus.RWHBS, bus.RADDR[1:0]);
  assign r_oor  = !r_mmio && (ridx >= DEPTH_IDX);
  assign w_unal = w_mmio ? (bus.WWHBS != SZ_WORD) : is_unaligned(bus.WWHBS, bus.WADDR[1:0]);
  assign w_oor  = !w_mmio && (widx >= DEPTH_IDX);

  assign wbe = (bus.WE && !w_mmio && !w_unal && !w_oor) ? lane_mask(bus.WWHBS, bus.WADDR[1:0])
                                                        : 4'b0000;

  always_comb begin
    case (bus.WWHBS)
      SZ_BYTE: wdata = {4{bus.DIN[7:0]}};
      SZ_HALF: wdata = {2{bus.DIN[15:0]}};
      default: wdata = bus.DIN;
    endcase
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (CLK),
    .re    (accept),
    .raddr (ridx[AW-1:0]),
    .rdata (arr_rdata),
    .we    (wbe),
    .waddr (widx[AW-1:0]),
    .wdata (wdata)
  );

  // All read faults resolve at accept, so read and write pulses can share one edge.
  assign runal_set = accept && r_unal;
  assign wunal_set = bus.WE && w_unal;
  assign oor_set   = (accept && r_oor) || (bus.WE && w_oor);

  always_comb begin
    cause_set              = '0;
    cause_set[CAUSE_RUNAL] = runal_set;
    cause_set[CAUSE_WUNAL] = wunal_set;
    cause_set[CAUSE_OOR]   = oor_set;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_ready_q <= 1'b1;
      rd_valid_q <= 1'b0;
      runal_q    <= 1'b0;
      lat_sz     <= SZ_WORD;
      lat_a      <= '0;
      lat_ok     <= 1'b0;
      lat_mmio   <= 1'b0;
      lat_tmr    <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      runal_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_sz     <= bus.RWHBS;
            lat_a      <= bus.RADDR[1:0];
            lat_ok     <= !r_unal && !r_oor;
            lat_mmio   <= r_mmio && !r_unal;
            lat_tmr    <= tmr;
            rd_ready_q <= 1'b0;
            if (r_unal || r_oor || WAIT_CYCLES == 0) begin
              state      <= RESP;
              rd_valid_q <= 1'b1;
              runal_q    <= r_unal;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= RESP;
            rd_valid_q <= 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          rd_ready_q <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          rd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wunal_q <= 1'b0;
      oor_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      wunal_q <= wunal_set;
      oor_q   <= oor_set;
      cause_q <= (bus.exc_clr ? 3'b000 : cause_q) | cause_set;
    end
  end

  assign bus.rd_ready  = rd_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.RUnalExc  = runal_q;
  assign bus.WUnalExc  = wunal_q;
  assign bus.oor_err   = oor_q;
  assign bus.exc_cause = cause_q;
  assign bus.RAMData   = lat_mmio ? lat_tmr
                       : lat_ok   ? lane_extract(arr_rdata, lat_sz, lat_a)
                       : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with 2 read wait-states, a second
// with 4 wait-states for the mid-read reset case. DEPTH is 16 words.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst, rstb;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [31:0] rdata;
  int          lat;
  logic        runal, roor;
  logic [2:0]  rcause;
  int          nv;

  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(32)) ifa ();
  dmem_if #(.ADDR_W(32)) ifb ();

  dmem_ctrl #(.ADDR_W(32), .DEPTH(16), .WAIT_CYCLES(2)) dut_a (
    .CLK (clk), .rst (rst), .bus (ifa)
  );

  dmem_ctrl #(.ADDR_W(32), .DEPTH(16), .WAIT_CYCLES(4)) dut_b (
    .CLK (clk), .rst (rstb), .bus (ifb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] d);
    @(negedge clk);
    ifa.WE = 1'b1; ifa.WADDR = addr; ifa.WWHBS = sz; ifa.DIN = d;
    @(negedge clk);
    ifa.WE = 1'b0;
  endtask

  // Optional same-edge word write to the read address.
  task automatic do_read(input logic [31:0] addr, input logic [1:0] sz,
                         input logic same_we, input logic [31:0] wd);
    @(negedge clk);
    check("rd_ready_idle", {31'b0, ifa.rd_ready}, 32'd1);
    ifa.rd_req = 1'b1; ifa.RADDR = addr; ifa.RWHBS = sz;
    if (same_we) begin
      ifa.WE = 1'b1; ifa.WADDR = addr; ifa.WWHBS = SZ_WORD; ifa.DIN = wd;
    end
    @(negedge clk);
    ifa.rd_req = 1'b0; ifa.WE = 1'b0;
    lat = 1;
    while (!ifa.rd_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!ifa.rd_valid) check("rd_timeout", 32'd0, 32'd1);
    rdata  = ifa.RAMData;
    runal  = ifa.RUnalExc;
    roor   = ifa.oor_err;
    rcause = ifa.exc_cause;
  endtask

  task automatic clr_exc;
    @(negedge clk);
    ifa.exc_clr = 1'b1;
    @(negedge clk);
    ifa.exc_clr = 1'b0;
    check("exc_clr", {29'b0, ifa.exc_cause}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rstb = 1'b1;
    ifa.rd_req = 0; ifa.RADDR = 0; ifa.RWHBS = 0; ifa.WE = 0; ifa.WADDR = 0;
    ifa.WWHBS = 0; ifa.DIN = 0; ifa.exc_clr = 0;
    ifb.rd_req = 0; ifb.RADDR = 0; ifb.RWHBS = 0; ifb.WE = 0; ifb.WADDR = 0;
    ifb.WWHBS = 0; ifb.DIN = 0; ifb.exc_clr = 0;
    repeat (2) @(negedge clk);
    check("rst_rd_ready", {31'b0, ifa.rd_ready}, 32'd1);
    check("rst_rd_valid", {31'b0, ifa.rd_valid}, 32'd0);
    check("rst_ramdata", ifa.RAMData, 32'd0);
    check("rst_oor", {31'b0, ifa.oor_err}, 32'd0);
    check("rst_cause", {29'b0, ifa.exc_cause}, 32'd0);
    rst = 1'b0; rstb = 1'b0;

    // word write then read with two wait-states
    do_write(32'h10, SZ_WORD, 32'hDEADBEEF);
    do_read(32'h10, SZ_WORD, 1'b0, 32'h0);
    check("w2_latency", lat, 32'd3);
    check("w2_data", rdata, 32'hDEADBEEF);
    check("w2_runal", {31'b0, runal}, 32'd0);
    @(negedge clk);
    check("rd_valid_pulse", {31'b0, ifa.rd_valid}, 32'd0);

    // byte/half lanes
    do_write(32'h10, SZ_WORD, 32'h11223344);
    do_write(32'h13, SZ_BYTE, 32'hFFFFFF5A);
    do_read(32'h10, SZ_WORD, 1'b0, 32'h0);
    check("byte_merge", rdata, 32'h5A223344);
    do_read(32'h13, SZ_BYTE, 1'b0, 32'h0);
    check("byte_rd_13", rdata, 32'h0000005A);
    do_read(32'h11, SZ_BYTE, 1'b0, 32'h0);
    check("byte_rd_11", rdata, 32'h00000033);
    do_read(32'h12, SZ_HALF, 1'b0, 32'h0);
    check("half_rd_12", rdata, 32'h00005A22);
    do_write(32'h14, SZ_WORD, 32'h0);
    do_write(32'h16, SZ_HALF, 32'h1234BEEF);
    do_read(32'h14, SZ_WORD, 1'b0, 32'h0);
    check("half_wr_16", rdata, 32'hBEEF0000);
    do_read(32'h14, SZ_HALF, 1'b0, 32'h0);
    check("half_rd_14", rdata, 32'h00000000);

    // unaligned half read
    do_read(32'h11, SZ_HALF, 1'b0, 32'h0);
    check("runal_latency", lat, 32'd1);
    check("runal_flag", {31'b0, runal}, 32'd1);
    check("runal_data", rdata, 32'd0);
    check("runal_cause", {29'b0, rcause}, 32'b001);
    check("runal_no_oor", {31'b0, roor}, 32'd0);
    clr_exc();

    // out-of-range write leaves word 0 (same low index bits) untouched
    do_write(32'h0, SZ_WORD, 32'h12345678);
    do_write(32'h40, SZ_WORD, 32'hCAFEF00D);
    check("oor_wr_pulse", {31'b0, ifa.oor_err}, 32'd1);
    check("oor_wr_wunal", {31'b0, ifa.WUnalExc}, 32'd0);
    check("oor_wr_cause", {29'b0, ifa.exc_cause}, 32'b100);
    @(negedge clk);
    check("oor_wr_one_cycle", {31'b0, ifa.oor_err}, 32'd0);
    do_read(32'h0, SZ_WORD, 1'b0, 32'h0);
    check("oor_wr_dropped", rdata, 32'h12345678);
    clr_exc();

    // out-of-range read
    do_read(32'h40, SZ_WORD, 1'b0, 32'h0);
    check("oor_rd_latency", lat, 32'd1);
    check("oor_rd_pulse", {31'b0, roor}, 32'd1);
    check("oor_rd_data", rdata, 32'd0);
    check("oor_rd_cause", {29'b0, rcause}, 32'b100);
    clr_exc();

    // unaligned word write dropped
    do_write(32'h20, SZ_WORD, 32'h0);
    do_write(32'h22, SZ_WORD, 32'hFFFFFFFF);
    check("wunal_pulse", {31'b0, ifa.WUnalExc}, 32'd1);
    check("wunal_no_oor", {31'b0, ifa.oor_err}, 32'd0);
    check("wunal_cause", {29'b0, ifa.exc_cause}, 32'b010);
    clr_exc();

    // same-edge write and read: read-before-write
    do_read(32'h20, SZ_WORD, 1'b1, 32'h1);
    check("rbw_old", rdata, 32'h0);
    do_read(32'h20, SZ_WORD, 1'b0, 32'h0);
    check("rbw_new", rdata, 32'h1);

    // illegal size read
    do_read(32'h0, SZ_ILL, 1'b0, 32'h0);
    check("ill_runal", {31'b0, runal}, 32'd1);
    check("ill_data", rdata, 32'd0);
    clr_exc();

    // instance B: reset during WAIT abandons the read
    @(negedge clk);
    ifb.WE = 1'b1; ifb.WADDR = 32'h0; ifb.WWHBS = SZ_WORD; ifb.DIN = 32'hA5A5A5A5;
    @(negedge clk);
    ifb.WE = 1'b0; ifb.rd_req = 1'b1; ifb.RADDR = 32'h0; ifb.RWHBS = SZ_WORD;
    @(negedge clk);
    ifb.rd_req = 1'b0;
    check("b_busy", {31'b0, ifb.rd_ready}, 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    rstb = 1'b0;
    check("b_rst_ready", {31'b0, ifb.rd_ready}, 32'd1);
    check("b_rst_valid", {31'b0, ifb.rd_valid}, 32'd0);
    nv = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifb.rd_valid) nv++;
    end
    check("b_no_valid", nv, 32'd0);
    ifb.rd_req = 1'b1;
    @(negedge clk);
    ifb.rd_req = 1'b0;
    lat = 1;
    while (!ifb.rd_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b_latency", lat, 32'd5);
    check("b_data", ifb.RAMData, 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
